pc_gen_multi: RTL and testbench

- Parametrised successor of the fetch-stage PC unit.
- Produces the next fetch PC for a front end delivering up to FETCH_WIDTH instructions per cycle.
- Registers the translated physical PC and its TLB attributes alongside the PC.
- New capability: a branch or exception redirect arriving while the stage is disabled (pc_en=0) is latched and applied once pc_en returns, instead of being dropped.

---
 rtl/pc_gen_multi_pkg.sv | 20 ++
 rtl/pc_redirect_latch.sv | 69 ++++++
 rtl/pc_gen_multi.sv | 92 +++++++++
 tb/tb_pc_gen_multi.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pc_gen_multi_pkg.sv
// Shared constants and types for the multi-issue fetch PC generator.
// Holds the reset vector, instruction size, TLB attribute bundle and FSM states.
package pc_gen_multi_pkg;

    localparam logic [31:0] PC_RESET_VECTOR = 32'hbfc0_0000;
    localparam int unsigned INST_BYTES      = 4;

    typedef struct packed {
        logic miss;
        logic illegal;
        logic invalid;
        logic uncached;
    } tlb_attr_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } redir_state_e;

endpackage

// File: rtl/pc_redirect_latch.sv
// Holds a redirect that arrived while the fetch stage was stalled and merges it
// with new redirects: new exception > pending exception > new branch > pending branch.
module pc_redirect_latch
    import pc_gen_multi_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_en,
    input  logic        branch_taken,
    input  logic [31:0] branch_address,
    input  logic        exception_taken,
    input  logic [31:0] exception_address,
    output logic        redirect_valid,
    output logic [31:0] redirect_addr,
    output logic        redirect_pending
);

    redir_state_e state_q, state_d;
    logic [31:0]  pend_addr_q, pend_addr_d;
    logic         pend_exc_q, pend_exc_d;
    logic         hold;

    assign hold             = (state_q == ST_HOLD);
    assign redirect_pending = hold;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        pend_addr_d = pend_addr_q;
        pend_exc_d  = pend_exc_q;
        if (pc_en) begin
            // Any pending redirect is consumed by the combine below this cycle.
            state_d    = ST_RUN;
            pend_exc_d = 1'b0;
        end else if (exception_taken) begin
            state_d     = ST_HOLD;
            pend_addr_d = exception_address;
            pend_exc_d  = 1'b1;
        end else if (branch_taken && !(hold && pend_exc_q)) begin
            state_d     = ST_HOLD;
            pend_addr_d = branch_address;
            pend_exc_d  = 1'b0;
        end
    end

    always_comb begin
        redirect_valid = 1'b1;
        redirect_addr  = '0;
        if (exception_taken)         redirect_addr = exception_address;
        else if (hold && pend_exc_q) redirect_addr = pend_addr_q;
        else if (branch_taken)       redirect_addr = branch_address;
        else if (hold)               redirect_addr = pend_addr_q;
        else                         redirect_valid = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            pend_addr_q <= '0;
            pend_exc_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
            pend_exc_q  <= pend_exc_d;
        end
    end

endmodule

// File: rtl/pc_gen_multi.sv
// Fetch-stage PC generator for up to FETCH_WIDTH instructions per cycle, with
// registered physical PC / TLB attributes and redirects deferred across stalls.
module pc_gen_multi
    import pc_gen_multi_pkg::*;
#(
    parameter int          FETCH_WIDTH  = 2,
    parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR,
    parameter int          CNT_W        = $clog2(FETCH_WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_en,
    input  logic             fifo_full,
    input  logic [CNT_W-1:0] inst_cnt,
    input  logic             branch_taken,
    input  logic [31:0]      branch_address,
    input  logic             exception_taken,
    input  logic [31:0]      exception_address,
    output logic [31:0]      pc_address_next,
    input  logic [31:0]      pc_address_psy_next,
    input  logic             pc_tlb_miss,
    input  logic             pc_tlb_illegal,
    input  logic             pc_tlb_invalid,
    input  logic             pc_tlb_uncached,
    output logic [31:0]      pc_address,
    output logic [31:0]      pc_address_psy,
    output logic             tlb_miss,
    output logic             tlb_illegal,
    output logic             tlb_invalid,
    output logic             tlb_uncached,
    output logic             redirect_pending
);

    logic             redirect_valid;
    logic [31:0]      redirect_addr;
    logic [CNT_W-1:0] cnt_sat;
    logic [31:0]      pc_address_q, pc_address_d;
    logic [31:0]      pc_address_psy_q, pc_address_psy_d;
    tlb_attr_t        tlb_q, tlb_d;

    pc_redirect_latch u_redirect (
        .clk               (clk),
        .rst               (rst),
        .pc_en             (pc_en),
        .branch_taken      (branch_taken),
        .branch_address    (branch_address),
        .exception_taken   (exception_taken),
        .exception_address (exception_address),
        .redirect_valid    (redirect_valid),
        .redirect_addr     (redirect_addr),
        .redirect_pending  (redirect_pending)
    );

    assign cnt_sat = (inst_cnt > CNT_W'(FETCH_WIDTH)) ? CNT_W'(FETCH_WIDTH) : inst_cnt;

    always_comb begin
        pc_address_d = pc_address_q;
        if (rst)
            pc_address_d = RESET_VECTOR;
        else if (pc_en) begin
            if (redirect_valid)
                pc_address_d = redirect_addr;
            else if (!fifo_full)
                pc_address_d = pc_address_q + 32'(cnt_sat) * 32'(INST_BYTES);
        end
    end

    assign pc_address_next  = pc_address_d;
    assign pc_address_psy_d = pc_address_psy_next;
    assign tlb_d            = '{miss: pc_tlb_miss, illegal: pc_tlb_illegal,
                                invalid: pc_tlb_invalid, uncached: pc_tlb_uncached};

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_address_q     <= RESET_VECTOR;
            pc_address_psy_q <= '0;
            tlb_q            <= '0;
        end else begin
            pc_address_q     <= pc_address_d;
            pc_address_psy_q <= pc_address_psy_d;
            tlb_q            <= tlb_d;
        end
    end

    assign pc_address     = pc_address_q;
    assign pc_address_psy = pc_address_psy_q;
    assign tlb_miss       = tlb_q.miss;
    assign tlb_illegal    = tlb_q.illegal;
    assign tlb_invalid    = tlb_q.invalid;
    assign tlb_uncached   = tlb_q.uncached;

endmodule

// File: tb/tb_pc_gen_multi.sv
// Self-checking bench for pc_gen_multi (FETCH_WIDTH=4): directed scenarios
// followed by random traffic, all compared against a behavioural model.
module tb_pc_gen_multi;

    localparam int          FW    = 4;
    localparam int          CW    = $clog2(FW + 1);
    localparam logic [31:0] RV    = 32'hbfc0_0000;

    logic          clk = 1'b0;
    logic          rst, pc_en, fifo_full, branch_taken, exception_taken;
    logic [CW-1:0] inst_cnt;
    logic [31:0]   branch_address, exception_address, pc_address_next;
    logic [31:0]   pc_address_psy_next, pc_address, pc_address_psy;
    logic          pc_tlb_miss, pc_tlb_illegal, pc_tlb_invalid, pc_tlb_uncached;
    logic          tlb_miss, tlb_illegal, tlb_invalid, tlb_uncached, redirect_pending;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: current PC and an optional deferred redirect.
    logic [31:0] m_pc;
    bit          m_pend;
    bit          m_pend_exc;
    logic [31:0] m_pend_addr;

    always #5 clk = ~clk;

    pc_gen_multi #(.FETCH_WIDTH(FW), .RESET_VECTOR(RV)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .pc_en               (pc_en),
        .fifo_full           (fifo_full),
        .inst_cnt            (inst_cnt),
        .branch_taken        (branch_taken),
        .branch_address      (branch_address),
        .exception_taken     (exception_taken),
        .exception_address   (exception_address),
        .pc_address_next     (pc_address_next),
        .pc_address_psy_next (pc_address_psy_next),
        .pc_tlb_miss         (pc_tlb_miss),
        .pc_tlb_illegal      (pc_tlb_illegal),
        .pc_tlb_invalid      (pc_tlb_invalid),
        .pc_tlb_uncached     (pc_tlb_uncached),
        .pc_address          (pc_address),
        .pc_address_psy      (pc_address_psy),
        .tlb_miss            (tlb_miss),
        .tlb_illegal         (tlb_illegal),
        .tlb_invalid         (tlb_invalid),
        .tlb_uncached        (tlb_uncached),
        .redirect_pending    (redirect_pending)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Expected next PC from the current model state and the applied inputs.
    function automatic logic [31:0] model_next();
        int unsigned n;
        if (rst)                        return RV;
        if (!pc_en)                     return m_pc;
        if (exception_taken)            return exception_address;
        if (m_pend && m_pend_exc)       return m_pend_addr;
        if (branch_taken)               return branch_address;
        if (m_pend)                     return m_pend_addr;
        if (fifo_full)                  return m_pc;
        n = (int'(inst_cnt) > FW) ? FW : int'(inst_cnt);
        return m_pc + 32'(4 * n);
    endfunction

    // One clock cycle: drive inputs, check the combinational next PC, clock, check registers.
    task automatic cyc(input bit r, input bit en, input bit ff, input int cnt,
                       input bit br, input logic [31:0] ba,
                       input bit ex, input logic [31:0] ea);
        logic [31:0] exp_next, exp_psy;
        logic [3:0]  exp_tlb;
        rst = r; pc_en = en; fifo_full = ff; inst_cnt = CW'(cnt);
        branch_taken = br; branch_address = ba;
        exception_taken = ex; exception_address = ea;
        pc_address_psy_next = $urandom;
        {pc_tlb_miss, pc_tlb_illegal, pc_tlb_invalid, pc_tlb_uncached} = 4'($urandom);
        #1;
        exp_next = model_next();
        exp_psy  = r ? 32'h0 : pc_address_psy_next;
        exp_tlb  = r ? 4'h0 : {pc_tlb_miss, pc_tlb_illegal, pc_tlb_invalid, pc_tlb_uncached};
        check("pc_address_next", pc_address_next, exp_next);
        if (r) begin
            m_pend = 0; m_pend_exc = 0;
        end else if (en) begin
            m_pend = 0; m_pend_exc = 0;
        end else if (ex) begin
            m_pend = 1; m_pend_exc = 1; m_pend_addr = ea;
        end else if (br && !(m_pend && m_pend_exc)) begin
            m_pend = 1; m_pend_exc = 0; m_pend_addr = ba;
        end
        m_pc = exp_next;
        @(posedge clk);
        #1;
        check("pc_address", pc_address, m_pc);
        check("pc_address_psy", pc_address_psy, exp_psy);
        check("tlb_attr", 32'({tlb_miss, tlb_illegal, tlb_invalid, tlb_uncached}), 32'(exp_tlb));
        check("redirect_pending", 32'(redirect_pending), 32'(m_pend));
        @(negedge clk);
    endtask

    initial begin
        m_pc = 32'h0; m_pend = 0; m_pend_exc = 0; m_pend_addr = 32'h0;
        @(negedge clk);

        // Reset then sequential fetch of two instructions per cycle.
        cyc(1, 1, 0, 2, 0, 0, 0, 0);
        check("reset_pc", pc_address, RV);
        check("reset_tlb", 32'({tlb_miss, tlb_illegal, tlb_invalid, tlb_uncached}), 32'h0);
        cyc(0, 1, 0, 2, 0, 0, 0, 0);
        check("seq_pc1", pc_address, 32'hbfc0_0008);
        cyc(0, 1, 0, 2, 0, 0, 0, 0);
        check("seq_pc2", pc_address, 32'hbfc0_0010);

        // Saturation of inst_cnt and 32-bit wrap.
        cyc(0, 1, 0, 0, 1, 32'h0000_1000, 0, 0);
        cyc(0, 1, 0, 7, 0, 0, 0, 0);
        check("saturate", pc_address, 32'h0000_1010);
        cyc(0, 1, 0, 0, 1, 32'hffff_fffc, 0, 0);
        cyc(0, 1, 0, 1, 0, 0, 0, 0);
        check("wrap", pc_address, 32'h0000_0000);

        // Exception beats branch and fifo_full.
        cyc(0, 1, 1, 3, 1, 32'h0000_1234, 1, 32'h8000_0180);
        check("exc_priority", pc_address, 32'h8000_0180);

        // Branch while stalled is deferred until pc_en returns.
        cyc(0, 0, 0, 2, 1, 32'h0000_2000, 0, 0);
        check("stall_hold_pc", pc_address, 32'h8000_0180);
        check("stall_pending", 32'(redirect_pending), 32'h1);
        cyc(0, 0, 0, 2, 0, 0, 0, 0);
        cyc(0, 0, 0, 2, 0, 0, 0, 0);
        cyc(0, 1, 0, 2, 0, 0, 0, 0);
        check("deferred_branch", pc_address, 32'h0000_2000);
        check("deferred_cleared", 32'(redirect_pending), 32'h0);

        // A pending exception is not displaced by later branches.
        cyc(0, 0, 0, 1, 0, 0, 1, 32'h8000_0180);
        cyc(0, 0, 0, 1, 1, 32'h0000_3000, 0, 0);
        cyc(0, 1, 0, 1, 1, 32'h0000_4000, 0, 0);
        check("pend_exc_wins", pc_address, 32'h8000_0180);

        // Reset discards a pending redirect and ignores a concurrent one.
        cyc(0, 0, 0, 1, 1, 32'h0000_5000, 0, 0);
        cyc(1, 1, 0, 1, 0, 0, 1, 32'h8000_0180);
        check("rst_pc", pc_address, RV);
        check("rst_pending", 32'(redirect_pending), 32'h0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        check("rst_discard", pc_address, RV);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] ba, ea;
            ba = {$urandom} & 32'hffff_fffc;
            ea = ($urandom_range(0, 3) == 0) ? 32'hffff_fffc : ({$urandom} & 32'hffff_fffc);
            cyc($urandom_range(0, 39) == 0,
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 4) == 0,
                $urandom_range(0, 7),
                $urandom_range(0, 6) == 0, ba,
                $urandom_range(0, 11) == 0, ea);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
